// File: rtl/render_pkg.sv
// render_pkg: shared types and constants for the note sprite renderer.
//   note_slot_t : one sprite slot {valid, x, y, rgb}. The rgb field is sized
//                 for the widest supported channel (8 bits); narrower
//                 configurations keep their colour in the low bits.
//   H_VISIBLE / V_VISIBLE : visible raster size.
package render_pkg;

   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;

   // COLOR_W up to 8 fits in the shared slot layout.
   localparam int RGB_W_MAX = 24;

   typedef struct packed {
      logic                 valid;
      logic [9:0]           x;
      logic [9:0]           y;
      logic [RGB_W_MAX-1:0] rgb;
   } note_slot_t;

endpackage

// File: rtl/note_hit.sv
// note_hit: combinational hit test of one pixel against one sprite slot.
//   slot_i : sprite slot (valid, top-left x/y; rgb is not used here)
//   px_i   : pixel column
//   py_i   : pixel row
//   hit_o  : slot is valid and the pixel lies inside its NOTE_W x NOTE_H box
module note_hit
   import render_pkg::*;
#(
   parameter int NOTE_W = 16,
   parameter int NOTE_H = 8
) (
   input  note_slot_t slot_i,
   input  logic [9:0] px_i,
   input  logic [9:0] py_i,
   output logic       hit_o
);

   // 11-bit bounds so a box reaching past column/row 1023 does not wrap.
   logic [10:0] x_lo, x_hi, y_lo, y_hi, px, py;
   logic        unused_rgb;

   assign px   = {1'b0, px_i};
   assign py   = {1'b0, py_i};
   assign x_lo = {1'b0, slot_i.x};
   assign y_lo = {1'b0, slot_i.y};
   assign x_hi = x_lo + 11'(NOTE_W - 1);
   assign y_hi = y_lo + 11'(NOTE_H - 1);

   assign hit_o = slot_i.valid
                  && (px >= x_lo) && (px <= x_hi)
                  && (py >= y_lo) && (py <= y_hi);

   assign unused_rgb = ^slot_i.rgb;

endmodule

// File: rtl/note_renderer.sv
// note_renderer: composites up to NUM_NOTES rectangular sprites over the
// ledger background and drives the VGA pins.
//   Clk, Reset          : clock, synchronous active-high reset
//   pixel_en            : pixel strobe; the two-stage pipeline moves only on it
//   DrawX, DrawY, blank : current pixel and blanking flag
//   hs_in, vs_in        : syncs from vga_controller (active-low)
//   bck_red/green/blue  : background colour
//   wr_en, wr_slot, wr_valid, wr_x, wr_y, wr_rgb : shadow slot write port
//   hs, vs              : syncs delayed to match the colour pipeline
//   red, green, blue    : final pixel colour
//   frame_done          : one-cycle pulse when the shadow bank is committed
module note_renderer
   import render_pkg::*;
#(
   parameter  int NUM_NOTES = 8,
   parameter  int COLOR_W   = 4,
   parameter  int NOTE_W    = 16,
   parameter  int NOTE_H    = 8,
   localparam int SLOT_W    = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 pixel_en,
   input  logic [9:0]           DrawX,
   input  logic [9:0]           DrawY,
   input  logic                 blank,
   input  logic                 hs_in,
   input  logic                 vs_in,
   input  logic [COLOR_W-1:0]   bck_red,
   input  logic [COLOR_W-1:0]   bck_green,
   input  logic [COLOR_W-1:0]   bck_blue,
   input  logic                 wr_en,
   input  logic [SLOT_W-1:0]    wr_slot,
   input  logic                 wr_valid,
   input  logic [9:0]           wr_x,
   input  logic [9:0]           wr_y,
   input  logic [3*COLOR_W-1:0] wr_rgb,
   output logic                 hs,
   output logic                 vs,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue,
   output logic                 frame_done
);

   localparam int RGB_W = 3 * COLOR_W;

   // Sprite banks
   note_slot_t shadow_q [NUM_NOTES];
   note_slot_t shadow_d [NUM_NOTES];
   note_slot_t active_q [NUM_NOTES];
   note_slot_t active_d [NUM_NOTES];

   logic vs_prev_q;
   logic frame_done_q;
   logic commit;

   // Stage 1 registers
   logic [9:0]       s1_x_q, s1_y_q;
   logic             s1_blank_q, s1_hs_q, s1_vs_q;
   logic [RGB_W-1:0] s1_bck_q;

   // Stage 2 registers
   logic             s2_hit_q, s2_blank_q, s2_hs_q, s2_vs_q;
   logic [RGB_W-1:0] s2_rgb_q, s2_bck_q;

   logic [NUM_NOTES-1:0] hit;
   logic                 any_hit;
   logic [RGB_W-1:0]     win_rgb;

   assign commit = vs_prev_q & ~vs_in;

   // Commit reads the old shadow, so a write landing in the commit cycle
   // stays in the shadow until the following commit.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (commit) begin
         active_d = shadow_q;
      end
      if (wr_en && (int'(wr_slot) < NUM_NOTES)) begin
         shadow_d[wr_slot] = '{valid: wr_valid, x: wr_x, y: wr_y,
                               rgb: RGB_W_MAX'(wr_rgb)};
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < NUM_NOTES; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         // Track vs_in during reset so a low vs_in at release is not a fall.
         vs_prev_q    <= vs_in;
         frame_done_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         vs_prev_q    <= vs_in;
         frame_done_q <= commit;
      end
   end

   generate
      for (genvar g = 0; g < NUM_NOTES; g++) begin : g_hit
         note_hit #(
            .NOTE_W (NOTE_W),
            .NOTE_H (NOTE_H)
         ) u_note_hit (
            .slot_i (active_q[g]),
            .px_i   (s1_x_q),
            .py_i   (s1_y_q),
            .hit_o  (hit[g])
         );
      end
   endgenerate

   // Lowest-index hitting slot wins.
   always_comb begin
      any_hit = 1'b0;
      win_rgb = '0;
      for (int unsigned i = 0; i < NUM_NOTES; i++) begin
         if (hit[i] && !any_hit) begin
            any_hit = 1'b1;
            win_rgb = active_q[i].rgb[RGB_W-1:0];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_blank_q <= 1'b0;
         s1_bck_q   <= '0;
         s1_hs_q    <= 1'b1;
         s1_vs_q    <= 1'b1;
         s2_hit_q   <= 1'b0;
         s2_rgb_q   <= '0;
         s2_bck_q   <= '0;
         s2_blank_q <= 1'b0;
         s2_hs_q    <= 1'b1;
         s2_vs_q    <= 1'b1;
      end else if (pixel_en) begin
         s1_x_q     <= DrawX;
         s1_y_q     <= DrawY;
         s1_blank_q <= blank;
         s1_bck_q   <= {bck_red, bck_green, bck_blue};
         s1_hs_q    <= hs_in;
         s1_vs_q    <= vs_in;
         s2_hit_q   <= any_hit;
         s2_rgb_q   <= win_rgb;
         s2_bck_q   <= s1_bck_q;
         s2_blank_q <= s1_blank_q;
         s2_hs_q    <= s1_hs_q;
         s2_vs_q    <= s1_vs_q;
      end
   end

   assign {red, green, blue} = s2_blank_q ? '0 : (s2_hit_q ? s2_rgb_q : s2_bck_q);
   assign hs         = s2_hs_q;
   assign vs         = s2_vs_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_note_renderer.sv
// tb_note_renderer: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural frame/sprite model.
module tb_note_renderer;
   import render_pkg::*;

   localparam int N  = 6;
   localparam int CW = 4;
   localparam int NW = 16;
   localparam int NH = 8;
   localparam int SW = 3;
   localparam int CMASK = (1 << CW) - 1;

   logic          Clk = 1'b0;
   logic          Reset, pixel_en, blank, hs_in, vs_in;
   logic [9:0]    DrawX, DrawY, wr_x, wr_y;
   logic [CW-1:0] bck_red, bck_green, bck_blue;
   logic          wr_en, wr_valid;
   logic [SW-1:0] wr_slot;
   logic [3*CW-1:0] wr_rgb;
   logic          hs, vs, frame_done;
   logic [CW-1:0] red, green, blue;

   note_renderer #(
      .NUM_NOTES (N),
      .COLOR_W   (CW),
      .NOTE_W    (NW),
      .NOTE_H    (NH)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .pixel_en   (pixel_en),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .blank      (blank),
      .hs_in      (hs_in),
      .vs_in      (vs_in),
      .bck_red    (bck_red),
      .bck_green  (bck_green),
      .bck_blue   (bck_blue),
      .wr_en      (wr_en),
      .wr_slot    (wr_slot),
      .wr_valid   (wr_valid),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_rgb     (wr_rgb),
      .hs         (hs),
      .vs         (vs),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .frame_done (frame_done)
   );

   always #5 Clk = ~Clk;

   int passes = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { bit v; int x; int y; int rgb; } mslot_t;
   mslot_t sh [N];
   mslot_t ac [N];
   int  p_x, p_y, p_blank, p_bck, p_hs, p_vs;   // pixel presented at the previous strobe
   int  e_rgb = 0, e_hs = 1, e_vs = 1, e_fd = 0;
   bit  vs_last;
   bit  model_ok = 1'b0;

   function automatic int colour(input int px, input int py, input int b, input int bck);
      if (b != 0) return 0;
      for (int i = 0; i < N; i++)
         if (ac[i].v && px >= ac[i].x && px < ac[i].x + NW && py >= ac[i].y && py < ac[i].y + NH)
            return ac[i].rgb;
      return bck;
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N; i++) begin
            sh[i] = '{0, 0, 0, 0};
            ac[i] = '{0, 0, 0, 0};
         end
         p_x = 0; p_y = 0; p_blank = 0; p_bck = 0; p_hs = 1; p_vs = 1;
         e_rgb = 0; e_hs = 1; e_vs = 1; e_fd = 0;
         vs_last = vs_in;
         model_ok = 1'b1;
      end else begin
         if (pixel_en) begin
            e_rgb = colour(p_x, p_y, p_blank, p_bck);
            e_hs  = p_hs;
            e_vs  = p_vs;
            p_x = int'(DrawX); p_y = int'(DrawY); p_blank = int'(blank);
            p_bck = int'({bck_red, bck_green, bck_blue});
            p_hs = int'(hs_in); p_vs = int'(vs_in);
         end
         e_fd = (vs_last && !vs_in) ? 1 : 0;
         if (e_fd != 0) ac = sh;
         vs_last = vs_in;
         if (wr_en && int'(wr_slot) < N)
            sh[wr_slot] = '{wr_valid, int'(wr_x), int'(wr_y), int'(wr_rgb)};
      end
   end

   always @(negedge Clk) begin
      if (model_ok) begin
         check("red",        int'(red),        (e_rgb >> (2*CW)) & CMASK);
         check("green",      int'(green),      (e_rgb >> CW) & CMASK);
         check("blue",       int'(blue),       e_rgb & CMASK);
         check("hs",         int'(hs),         e_hs);
         check("vs",         int'(vs),         e_vs);
         check("frame_done", int'(frame_done), e_fd);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic wr(input int slot, input bit v, input int x, input int y, input int rgb);
      wr_en = 1'b1; wr_slot = SW'(slot); wr_valid = v;
      wr_x = 10'(x); wr_y = 10'(y); wr_rgb = 12'(rgb);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic commit_frame();
      vs_in = 1'b0;
      tick(1);
      check("frame_done_pulse", int'(frame_done), 1);
      vs_in = 1'b1;
      tick(1);
      check("frame_done_single", int'(frame_done), 0);
   endtask

   task automatic pix(input string nm, input int x, input int y, input int exp_rgb);
      DrawX = 10'(x); DrawY = 10'(y);
      tick(3);
      check(nm, int'({red, green, blue}), exp_rgb);
   endtask

   initial begin
      Reset = 1'b1; pixel_en = 1'b1; blank = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
      DrawX = '0; DrawY = '0; bck_red = '0; bck_green = '0; bck_blue = '0;
      wr_en = 1'b0; wr_slot = '0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
      tick(3);
      check("reset_rgb", int'({red, green, blue}), 0);
      check("reset_hs",  int'(hs), 1);
      check("reset_vs",  int'(vs), 1);
      check("reset_fd",  int'(frame_done), 0);
      Reset = 1'b0;

      // Background only
      bck_red = 4'hA; bck_green = 4'h5; bck_blue = 4'h3;
      pix("background", 0, 0, 'hA53);
      blank = 1'b1;
      pix("blank_bg", 0, 0, 'h000);
      blank = 1'b0;

      // Single sprite
      wr(0, 1, 100, 50, 'hF00);
      pix("pre_commit_hidden", 100, 50, 'hA53);
      commit_frame();
      pix("sprite_tl",   100, 50, 'hF00);
      pix("sprite_br",   115, 57, 'hF00);
      pix("sprite_xout", 116, 50, 'hA53);
      pix("sprite_yout", 100, 58, 'hA53);
      blank = 1'b1;
      pix("blank_sprite", 100, 50, 'h000);
      blank = 1'b0;

      // Priority
      wr(2, 1, 200, 200, 'h0F0);
      wr(5, 1, 195, 196, 'h00F);
      commit_frame();
      pix("priority",    200, 200, 'h0F0);
      pix("low_only5",   195, 196, 'h00F);

      // Double buffering
      wr(1, 1, 300, 300, 'h0FF);
      pix("midframe_hidden", 300, 300, 'hA53);
      commit_frame();
      pix("next_frame_vis",  300, 300, 'h0FF);

      // Write in the commit cycle
      wr_en = 1'b1; wr_slot = 3'd3; wr_valid = 1'b1; wr_x = 10'd400; wr_y = 10'd400; wr_rgb = 12'h888;
      vs_in = 1'b0;
      tick(1);
      check("commit_cycle_fd", int'(frame_done), 1);
      wr_en = 1'b0; vs_in = 1'b1;
      tick(1);
      pix("same_cycle_hidden", 400, 400, 'hA53);
      commit_frame();
      pix("same_cycle_late",   400, 400, 'h888);

      // Right-edge sprite does not wrap
      wr(4, 1, 1020, 10, 'hFFF);
      commit_frame();
      pix("edge_1020", 1020, 10, 'hFFF);
      pix("edge_1023", 1023, 10, 'hFFF);
      pix("no_wrap_0", 0,    10, 'hA53);
      pix("no_wrap_3", 3,    10, 'hA53);

      // Out-of-range slots ignored
      wr(6, 1, 500, 100, 'hF0F);
      wr(7, 1, 520, 100, 'h0F0);
      commit_frame();
      pix("slot6_ignored", 500, 100, 'hA53);
      pix("slot7_ignored", 520, 100, 'hA53);
      pix("slot0_intact",  100, 50,  'hF00);

      // Reset mid-frame
      Reset = 1'b1;
      tick(1);
      check("midreset_rgb", int'({red, green, blue}), 0);
      check("midreset_hs",  int'(hs), 1);
      check("midreset_vs",  int'(vs), 1);
      Reset = 1'b0;
      pix("cleared_active", 100, 50, 'hA53);
      commit_frame();
      pix("cleared_shadow", 100, 50, 'hA53);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         int mode;
         mode     = int'($urandom_range(0, 3));
         Reset    = ($urandom_range(0, 499) == 0);
         pixel_en = 1'($urandom_range(0, 1));
         blank    = ($urandom_range(0, 7) == 0);
         hs_in    = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 19) == 0) vs_in = ~vs_in;
         if (mode == 0) begin
            DrawX = 10'($urandom_range(0, 79));
            DrawY = 10'($urandom_range(0, 39));
         end else if (mode == 1) begin
            DrawX = 10'($urandom_range(1000, 1023));
            DrawY = 10'($urandom_range(0, 39));
         end else begin
            DrawX = 10'($urandom_range(0, H_VISIBLE - 1));
            DrawY = 10'($urandom_range(0, V_VISIBLE - 1));
         end
         bck_red   = CW'($urandom);
         bck_green = CW'($urandom);
         bck_blue  = CW'($urandom);
         wr_en     = ($urandom_range(0, 3) == 0);
         wr_slot   = SW'($urandom_range(0, 7));
         wr_valid  = ($urandom_range(0, 3) != 0);
         wr_x      = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 63))
                                                 : 10'($urandom_range(1000, 1023));
         wr_y      = 10'($urandom_range(0, 31));
         wr_rgb    = 12'($urandom);
         tick(1);
      end
      Reset = 1'b0; wr_en = 1'b0;
      tick(2);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
